uart_tlul_host: RTL and testbench

Serial-to-TL-UL bridge: decodes 8N1 command frames on a UART line and issues single-word TL-UL Get/PutFullData transactions as a bus host, returning status and read data over UART. It is the initiator-side counterpart of the `simple_uart` TL-UL device. It attaches as an additional host port on `xbar_main`, so an external PC can load and inspect the scratchpads without a core running.

---
 rtl/tlul_pkg.sv | 45 ++++
 rtl/uart_tlul_host_pkg.sv | 19 +
 rtl/uart_byte_phy.sv | 127 ++++++++++++
 rtl/uart_tlul_host.sv | 179 +++++++++++++++++
 tb/tb_uart_tlul_host.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlul_pkg.sv
// TL-UL channel types shared by hosts and devices on the crossbar.
// Single-word 32-bit data path with 8-bit source ids.
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef logic [15:0] tl_a_user_t;
  localparam tl_a_user_t TL_A_USER_DEFAULT = 16'h0;

  typedef struct packed {
    logic       a_valid;
    tl_a_op_e   a_opcode;
    logic [2:0] a_param;
    logic [1:0] a_size;
    logic [7:0] a_source;
    logic [31:0] a_address;
    logic [3:0] a_mask;
    logic [31:0] a_data;
    tl_a_user_t a_user;
    logic       d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic       d_valid;
    tl_d_op_e   d_opcode;
    logic [2:0] d_param;
    logic [1:0] d_size;
    logic [7:0] d_source;
    logic [0:0] d_sink;
    logic [31:0] d_data;
    logic [15:0] d_user;
    logic       d_error;
    logic       a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/uart_tlul_host_pkg.sv
// Frame opcodes, response codes and FSM states of the UART bus host.
// Shared by the top level and its testbench.
package uart_tlul_host_pkg;

  localparam logic [7:0] OpWrite = 8'h57;
  localparam logic [7:0] OpRead  = 8'h52;
  localparam logic [7:0] RspOk   = 8'h4B;
  localparam logic [7:0] RspErr  = 8'h45;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_REQ,
    ST_RSP,
    ST_SEND
  } state_e;

endpackage

// File: rtl/uart_byte_phy.sv
// 8N1 byte engines: oversampled RX with framing flag, TX with
// valid/ready that accepts the next byte during the last stop cycle.
module uart_byte_phy #(
  parameter int ClksPerBit = 1085
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o,
  output logic       rx_ferr_o,
  input  logic       tx_valid_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_ready_o,
  output logic       tx_idle_o,
  output logic       tx_o
);

  localparam int CW = $clog2(ClksPerBit + 1);
  localparam logic [CW-1:0] LastCnt = CW'(ClksPerBit - 1);
  localparam logic [CW-1:0] HalfCnt = CW'(ClksPerBit / 2 - 1);

  logic          r_rx_meta;
  logic          r_rx_sync;
  logic          r_rx_prev;
  logic          r_rx_busy;
  logic [CW-1:0] r_rx_cnt;
  logic [3:0]    r_rx_bit;
  logic [7:0]    r_rx_sh;
  logic          r_rx_valid;
  logic          r_rx_ferr;

  logic          r_tx;
  logic          r_tx_busy;
  logic [CW-1:0] r_tx_cnt;
  logic [3:0]    r_tx_bit;
  logic [8:0]    r_tx_sh;
  logic          w_tx_last;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_busy  <= 1'b0;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_sh    <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_meta  <= rx_i;
      r_rx_sync  <= r_rx_meta;
      r_rx_prev  <= r_rx_sync;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
      if (!r_rx_busy) begin
        if (r_rx_prev && !r_rx_sync) begin
          r_rx_busy <= 1'b1;
          r_rx_cnt  <= '0;
          r_rx_bit  <= '0;
        end
      end else if (r_rx_bit == 4'd0) begin
        // start-bit midpoint: a high line here was only a glitch
        if (r_rx_cnt == HalfCnt) begin
          r_rx_cnt <= '0;
          if (r_rx_sync) r_rx_busy <= 1'b0;
          else           r_rx_bit  <= 4'd1;
        end else begin
          r_rx_cnt <= r_rx_cnt + 1'b1;
        end
      end else if (r_rx_cnt != LastCnt) begin
        r_rx_cnt <= r_rx_cnt + 1'b1;
      end else begin
        r_rx_cnt <= '0;
        if (r_rx_bit == 4'd9) begin
          r_rx_busy  <= 1'b0;
          r_rx_valid <= r_rx_sync;
          r_rx_ferr  <= !r_rx_sync;
        end else begin
          r_rx_sh  <= {r_rx_sync, r_rx_sh[7:1]};
          r_rx_bit <= r_rx_bit + 1'b1;
        end
      end
    end
  end

  assign rx_valid_o = r_rx_valid;
  assign rx_ferr_o  = r_rx_ferr;
  assign rx_data_o  = r_rx_sh;

  assign w_tx_last  = r_tx_busy && (r_tx_cnt == LastCnt) &&
                      (r_tx_bit == 4'd9);
  assign tx_ready_o = !r_tx_busy || w_tx_last;
  assign tx_idle_o  = !r_tx_busy;
  assign tx_o       = r_tx;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tx      <= 1'b1;
      r_tx_busy <= 1'b0;
      r_tx_cnt  <= '0;
      r_tx_bit  <= '0;
      r_tx_sh   <= '0;
    end else if (tx_valid_i && tx_ready_o) begin
      r_tx      <= 1'b0;
      r_tx_sh   <= {1'b1, tx_data_i};
      r_tx_cnt  <= '0;
      r_tx_bit  <= '0;
      r_tx_busy <= 1'b1;
    end else if (r_tx_busy) begin
      if (r_tx_cnt != LastCnt) begin
        r_tx_cnt <= r_tx_cnt + 1'b1;
      end else begin
        r_tx_cnt <= '0;
        if (r_tx_bit == 4'd9) begin
          r_tx_busy <= 1'b0;
        end else begin
          r_tx     <= r_tx_sh[0];
          r_tx_sh  <= {1'b1, r_tx_sh[8:1]};
          r_tx_bit <= r_tx_bit + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tlul_host.sv
// UART command frames to single-word TL-UL Get/PutFullData host.
// One transaction in flight; status and read data returned on TX.
module uart_tlul_host #(
  parameter int ClockFrequency = 125_000_000,
  parameter int BaudRate       = 115_200,
  parameter int TimeoutCycles  = 1_000_000,
  parameter int SourceId       = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               uart_rx_i,
  output logic               uart_tx_o,
  output tlul_pkg::tl_h2d_t  tl_h_o,
  input  tlul_pkg::tl_d2h_t  tl_h_i,
  output logic               busy_o
);

  import uart_tlul_host_pkg::*;

  localparam int ClksPerBit = ClockFrequency / BaudRate;
  localparam int TW = $clog2(TimeoutCycles + 1);

  logic       w_rx_valid;
  logic [7:0] w_rx_data;
  logic       w_rx_ferr;
  logic       w_tx_valid;
  logic [7:0] w_tx_data;
  logic       w_tx_ready;
  logic       w_tx_idle;

  state_e        r_state;
  state_e        w_next;
  logic          r_is_read;
  logic [31:0]   r_addr;
  logic [31:0]   r_data;
  logic [1:0]    r_cnt;
  logic [TW-1:0] r_tmo;
  logic [31:0]   r_txq;
  logic [2:0]    r_left;
  logic          w_last;
  logic          w_tmo;
  logic          w_in_frame;
  logic          w_unused;

  uart_byte_phy #(
    .ClksPerBit (ClksPerBit)
  ) u_phy (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rx_i       (uart_rx_i),
    .rx_valid_o (w_rx_valid),
    .rx_data_o  (w_rx_data),
    .rx_ferr_o  (w_rx_ferr),
    .tx_valid_i (w_tx_valid),
    .tx_data_i  (w_tx_data),
    .tx_ready_o (w_tx_ready),
    .tx_idle_o  (w_tx_idle),
    .tx_o       (uart_tx_o)
  );

  assign w_last     = (r_cnt == 2'd3);
  assign w_tmo      = (r_tmo == TW'(TimeoutCycles - 1));
  assign w_in_frame = (r_state == ST_ADDR) || (r_state == ST_DATA);
  assign busy_o     = (r_state != ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // first response byte is handed to the TX engine on the transition
  // into SEND so its start bit appears in SEND's first cycle
  always_comb begin
    w_next     = r_state;
    w_tx_valid = 1'b0;
    w_tx_data  = RspErr;
    unique case (r_state)
      ST_IDLE: begin
        if (w_rx_valid) begin
          if (w_rx_data == OpWrite || w_rx_data == OpRead) begin
            w_next = ST_ADDR;
          end else begin
            w_next     = ST_SEND;
            w_tx_valid = 1'b1;
          end
        end
      end
      ST_ADDR: begin
        if (w_rx_ferr || w_tmo) begin
          w_next = ST_IDLE;
        end else if (w_rx_valid && w_last) begin
          if (w_rx_data[1:0] != 2'b00) begin
            w_next     = ST_SEND;
            w_tx_valid = 1'b1;
          end else if (r_is_read) begin
            w_next = ST_REQ;
          end else begin
            w_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_rx_ferr || w_tmo) w_next = ST_IDLE;
        else if (w_rx_valid && w_last) w_next = ST_REQ;
      end
      ST_REQ: begin
        if (tl_h_i.a_ready) w_next = ST_RSP;
      end
      ST_RSP: begin
        if (tl_h_i.d_valid) begin
          w_next     = ST_SEND;
          w_tx_valid = 1'b1;
          if (!tl_h_i.d_error) begin
            w_tx_data = r_is_read ? tl_h_i.d_data[31:24] : RspOk;
          end
        end
      end
      ST_SEND: begin
        w_tx_valid = (r_left != 3'd0);
        w_tx_data  = r_txq[31:24];
        if (r_left == 3'd0 && w_tx_idle) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_is_read <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_cnt     <= '0;
      r_tmo     <= '0;
      r_txq     <= '0;
      r_left    <= '0;
    end else begin
      r_tmo <= (w_in_frame && !w_rx_valid) ? r_tmo + 1'b1 : '0;
      if (r_state == ST_IDLE && w_rx_valid) begin
        r_is_read <= (w_rx_data == OpRead);
        r_cnt     <= '0;
        r_data    <= '0;
      end
      if (w_in_frame && w_rx_valid) r_cnt <= r_cnt + 1'b1;
      if (r_state == ST_ADDR && w_rx_valid) begin
        r_addr <= {r_addr[23:0], w_rx_data};
      end
      if (r_state == ST_DATA && w_rx_valid) begin
        r_data <= {r_data[23:0], w_rx_data};
      end
      if (r_state == ST_RSP && tl_h_i.d_valid) begin
        r_txq  <= {tl_h_i.d_data[23:0], RspOk};
        r_left <= (r_is_read && !tl_h_i.d_error) ? 3'd4 : 3'd0;
      end
      if (r_state == ST_SEND && w_tx_valid && w_tx_ready) begin
        r_txq  <= {r_txq[23:0], 8'h00};
        r_left <= r_left - 1'b1;
      end
    end
  end

  always_comb begin
    tl_h_o           = '0;
    tl_h_o.a_valid   = (r_state == ST_REQ);
    tl_h_o.a_opcode  = r_is_read ? tlul_pkg::Get : tlul_pkg::PutFullData;
    tl_h_o.a_param   = 3'd0;
    tl_h_o.a_size    = 2'd2;
    tl_h_o.a_source  = 8'(SourceId);
    tl_h_o.a_address = r_addr;
    tl_h_o.a_mask    = 4'hF;
    tl_h_o.a_data    = r_is_read ? 32'h0 : r_data;
    tl_h_o.a_user    = tlul_pkg::TL_A_USER_DEFAULT;
    tl_h_o.d_ready   = (r_state == ST_RSP);
  end

  assign w_unused = ^{tl_h_i.d_opcode, tl_h_i.d_param, tl_h_i.d_size,
                      tl_h_i.d_source, tl_h_i.d_sink, tl_h_i.d_user,
                      tl_h_i.d_data[23:0]};

endmodule

// File: tb/tb_uart_tlul_host.sv
// Self-checking bench: UART frame driver, TX decoder, TL-UL device
// model, vector table, corner sequences and random frames.
module tb_uart_tlul_host;
  import tlul_pkg::*;

  localparam int CF  = 160;
  localparam int BR  = 10;
  localparam int C   = CF / BR;
  localparam int TMO = 2000;
  localparam int SRC = 3;

  typedef struct {
    logic [71:0] frame;
    int          nfb;
    bit          bad_stop;
    bit          err;
    logic [39:0] tx;
    int          ntx;
    int          bus;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  logic    uart_rx = 1'b1;
  logic    uart_tx;
  logic    busy;
  tl_h2d_t tl_h_o;
  tl_d2h_t tl_h_i;

  int total = 0;
  int bad   = 0;

  logic [7:0]  rx_q[$];
  tl_h2d_t     bus_q[$];
  logic [31:0] dev_mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];
  int          dev_stall = 0;
  int          dev_lat   = 2;
  bit          dev_err   = 1'b0;
  vec_t        vecs[10];

  always #5 clk = ~clk;

  uart_tlul_host #(
    .ClockFrequency (CF),
    .BaudRate       (BR),
    .TimeoutCycles  (TMO),
    .SourceId       (SRC)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .uart_rx_i (uart_rx),
    .uart_tx_o (uart_tx),
    .tl_h_o    (tl_h_o),
    .tl_h_i    (tl_h_i),
    .busy_o    (busy)
  );

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] defval(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    uart_rx = 1'b0;
    repeat (C) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (C) @(posedge clk);
    end
    uart_rx = stop_ok;
    repeat (C) @(posedge clk);
    uart_rx = 1'b1;
    if (!stop_ok) repeat (C) @(posedge clk);
  endtask

  // TX line decoder
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge uart_tx);
      repeat (C / 2) @(posedge clk);
      #1;
      if (uart_tx == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(posedge clk);
          #1 b[i] = uart_tx;
        end
        repeat (C) @(posedge clk);
        #1 chk("tx_stop", 64'(uart_tx), 64'd1);
        rx_q.push_back(b);
      end
    end
  end

  // TL-UL device
  initial begin
    tl_h2d_t t;
    bit      got;
    tl_h_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (tl_h_o.a_valid && !rst) begin
        t = tl_h_o;
        for (int k = 0; k < dev_stall; k++) begin
          @(posedge clk);
          #1 chk("a_stable", 64'(tl_h_o != t), 64'd0);
        end
        tl_h_i.a_ready = 1'b1;
        @(posedge clk);
        #1 tl_h_i.a_ready = 1'b0;
        bus_q.push_back(t);
        if (t.a_opcode == PutFullData) dev_mem[t.a_address] = t.a_data;
        repeat (dev_lat) @(posedge clk);
        #1;
        tl_h_i.d_valid = 1'b1;
        tl_h_i.d_error = dev_err;
        tl_h_i.d_opcode = (t.a_opcode == Get) ? AccessAckData : AccessAck;
        if (dev_err) tl_h_i.d_data = 32'hBAD0BAD0;
        else if (t.a_opcode != Get) tl_h_i.d_data = 32'h0;
        else if (dev_mem.exists(t.a_address))
          tl_h_i.d_data = dev_mem[t.a_address];
        else tl_h_i.d_data = defval(t.a_address);
        got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
          got = tl_h_o.d_ready;
          @(posedge clk);
          #1;
        end
        tl_h_i.d_valid = 1'b0;
        tl_h_i.d_error = 1'b0;
      end
    end
  end

  task automatic wait_tx(input int n, input string nm);
    int k = 0;
    while (rx_q.size() < n && k < n * 12 * C + 1000) begin
      @(posedge clk);
      k++;
    end
    chk({nm, "_txwait"}, 64'(rx_q.size() >= n), 64'd1);
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    #1;
    while (busy && k < 4000) begin
      @(posedge clk);
      #1 k++;
    end
    chk({nm, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    logic [7:0] b;
    logic [7:0] e;
    tl_h2d_t    t;
    rx_q.delete();
    bus_q.delete();
    dev_err = v.err;
    for (int i = 0; i < v.nfb; i++) begin
      b = v.frame[71-8*i -: 8];
      send_byte(b, !(v.bad_stop && i == 0));
    end
    wait_tx(v.ntx, nm);
    wait_idle(nm);
    repeat (12 * C) @(posedge clk);
    chk({nm, "_ntx"}, 64'(rx_q.size()), 64'(v.ntx));
    for (int i = 0; i < v.ntx; i++) begin
      e = v.tx[39-8*i -: 8];
      chk({nm, "_txbyte"},
          (i < rx_q.size()) ? 64'(rx_q[i]) : 64'hFFFF, 64'(e));
    end
    chk({nm, "_nbus"}, 64'(bus_q.size()), 64'(v.bus != 0));
    if (v.bus != 0 && bus_q.size() > 0) begin
      t = bus_q[0];
      chk({nm, "_op"}, 64'(t.a_opcode), (v.bus == 1) ? 64'd0 : 64'd4);
      chk({nm, "_addr"}, 64'(t.a_address), 64'(v.addr));
      chk({nm, "_data"}, 64'(t.a_data), 64'(v.data));
      chk({nm, "_fixed"},
          {32'h0, 4'(t.a_mask), 2'(t.a_size), 3'(t.a_param),
           7'h0, 8'(t.a_source), 16'(t.a_user)},
          {32'h0, 4'hF, 2'd2, 3'd0, 7'h0, 8'(SRC), 16'h0});
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   k;
    bit   rd;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] x;

    vecs[0] = '{72'h57_00010000_DEADBEEF, 9, 0, 0, 40'h4B_00000000, 1, 1,
                32'h00010000, 32'hDEADBEEF};
    vecs[1] = '{72'h57_00010004_12345678, 9, 0, 0, 40'h4B_00000000, 1, 1,
                32'h00010004, 32'h12345678};
    vecs[2] = '{72'h52_00010004_00000000, 5, 0, 0, 40'h12345678_4B, 5, 2,
                32'h00010004, 32'h0};
    vecs[3] = '{72'h52_00010000_00000000, 5, 0, 0, 40'hDEADBEEF_4B, 5, 2,
                32'h00010000, 32'h0};
    vecs[4] = '{72'h52_00010002_00000000, 5, 0, 0, 40'h45_00000000, 1, 0,
                32'h0, 32'h0};
    vecs[5] = '{72'h52_00010000_00000000, 5, 0, 1, 40'h45_00000000, 1, 2,
                32'h00010000, 32'h0};
    vecs[6] = '{72'h33_00000000_00000000, 1, 0, 0, 40'h45_00000000, 1, 0,
                32'h0, 32'h0};
    vecs[7] = '{72'h57_00000000_00000000, 1, 1, 0, 40'h0, 0, 0,
                32'h0, 32'h0};
    vecs[8] = '{72'h57_00020008_CAFEF00D, 9, 0, 0, 40'h4B_00000000, 1, 1,
                32'h00020008, 32'hCAFEF00D};
    vecs[9] = '{72'h52_00020008_00000000, 5, 0, 0, 40'hCAFEF00D_4B, 5, 2,
                32'h00020008, 32'h0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 64'(uart_tx), 64'd1);
    chk("rst_avalid", 64'(tl_h_o.a_valid), 64'd0);
    chk("rst_dready", 64'(tl_h_o.d_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    repeat (4 * C) @(posedge clk);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // partial frame abandoned by the idle-line timeout
    rx_q.delete();
    bus_q.delete();
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    repeat (2) @(posedge clk);
    #1 chk("tmo_busy", 64'(busy), 64'd1);
    repeat (TMO + 100) @(posedge clk);
    #1 chk("tmo_idle", 64'(busy), 64'd0);
    chk("tmo_nobus", 64'(bus_q.size()), 64'd0);
    chk("tmo_notx", 64'(rx_q.size()), 64'd0);
    run_vec(vecs[3], "tmo_read");

    // A channel held off for 20 cycles
    dev_stall = 20;
    v = '{72'h57_00030000_0BADF00D, 9, 0, 0, 40'h4B_00000000, 1, 1,
          32'h00030000, 32'h0BADF00D};
    run_vec(v, "stall");
    dev_stall = 0;

    // reset while waiting for the D response
    dev_lat = 150;
    rx_q.delete();
    bus_q.delete();
    dev_err = 1'b0;
    x = 32'h52_000100;
    send_byte(x[31:24], 1'b1);
    send_byte(x[23:16], 1'b1);
    send_byte(x[15:8], 1'b1);
    send_byte(x[7:0], 1'b1);
    send_byte(8'h00, 1'b1);
    k = 0;
    #1;
    while (!tl_h_o.d_ready && k < 500) begin
      @(posedge clk);
      #1 k++;
    end
    chk("rsp_reached", 64'(tl_h_o.d_ready), 64'd1);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_avalid", 64'(tl_h_o.a_valid), 64'd0);
    chk("mid_rst_dready", 64'(tl_h_o.d_ready), 64'd0);
    chk("mid_rst_tx", 64'(uart_tx), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    repeat (250) @(posedge clk);
    chk("mid_rst_notx", 64'(rx_q.size()), 64'd0);
    dev_lat = 2;

    // random frames against a word-level memory model
    for (int n = 0; n < 10; n++) begin
      rd = 1'($urandom_range(0, 1));
      a  = 32'h2000 + 32'($urandom_range(0, 7) << 2);
      d  = $urandom;
      if (rd && $urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      v.bad_stop = 1'b0;
      v.err      = 1'b0;
      v.addr     = a;
      if (rd) begin
        v.frame = {8'h52, a, 32'h0};
        v.nfb   = 5;
        v.data  = 32'h0;
        if (a[1:0] != 2'b00) begin
          v.tx  = 40'h45_00000000;
          v.ntx = 1;
          v.bus = 0;
        end else begin
          x     = ref_mem.exists(a) ? ref_mem[a] : defval(a);
          v.tx  = {x, 8'h4B};
          v.ntx = 5;
          v.bus = 2;
        end
      end else begin
        v.frame    = {8'h57, a, d};
        v.nfb      = 9;
        v.data     = d;
        v.tx       = 40'h4B_00000000;
        v.ntx      = 1;
        v.bus      = 1;
        ref_mem[a] = d;
      end
      run_vec(v, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
